// File: rtl/uart_board_pkg.sv
// Shared types and timing constants for the UART board harness.
// Repeat-FSM state encoding and default 20 MHz timing values.
package uart_board_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   localparam int CLK_HZ              = 20_000_000;
   localparam int DEBOUNCE_10MS       = 200_000;
   localparam int REPEAT_DELAY_500MS  = 10_000_000;
   localparam int REPEAT_PERIOD_100MS = 2_000_000;

   // Counter width for a counter that holds 0 .. n-1 (never below 1 bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: optional inversion, 2-FF synchroniser,
// debounce counter, press/release pulses and hold-to-repeat FSM.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   btn_raw      : asynchronous raw pin
//   btn_level    : debounced pressed level
//   btn_press    : 1-cycle pulse on accepted press
//   btn_release  : 1-cycle pulse on accepted release
//   btn_repeat   : 1-cycle pulse per auto-repeat tick
//   btn_event    : press | repeat, registered
module btn_debounce_chan
   import uart_board_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat,
   output logic btn_event
);

   localparam int DW = cnt_w(DEBOUNCE_CYCLES);
   localparam int TW = cnt_w(max_i(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DLY_LOAD = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PER_LOAD = TW'(REPEAT_PERIOD - 1);
   localparam logic          INV      = (ACTIVE_LOW != 0);
   localparam logic          RPT_ON   = (REPEAT_EN != 0);

   logic          raw_in;
   logic          s1;
   logic          s2;
   logic          stable;
   logic [DW-1:0] cnt;
   logic          mismatch;
   logic          accept;
   logic          rise;
   logic          fall;

   rpt_state_t    state_q;
   rpt_state_t    state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic          rpt_d;

   // Inversion happens before the synchroniser so a held
   // active-low button looks identical to an active-high one.
   assign raw_in = btn_raw ^ INV;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   assign mismatch = s2 ^ stable;
   assign accept   = mismatch && (cnt == DB_LAST);
   assign rise     = accept && !stable;
   assign fall     = accept && stable;

   // Any cycle of agreement clears the count, so only an
   // uninterrupted run of DEBOUNCE_CYCLES mismatches is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable      <= 1'b0;
         cnt         <= '0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         btn_press   <= rise;
         btn_release <= fall;
         if (accept) begin
            stable <= ~stable;
            cnt    <= '0;
         end else if (mismatch) begin
            cnt <= cnt + DW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   assign btn_level = stable;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         btn_repeat <= 1'b0;
         btn_event  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         btn_repeat <= rpt_d;
         btn_event  <= rise | rpt_d;
      end
   end

   // The FSM loads its timer on the same edge that raises
   // btn_press, so the first tick lands REPEAT_DELAY cycles later.
   // A release wins over a timer expiry in the same cycle.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rpt_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rise && RPT_ON) begin
               state_d = DELAY;
               timer_d = DLY_LOAD;
            end
         end
         DELAY, REPEAT: begin
            if (fall) begin
               state_d = IDLE;
               timer_d = '0;
            end else if (timer_q == '0) begin
               rpt_d   = 1'b1;
               state_d = REPEAT;
               timer_d = PER_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_debounce_repeat.sv
// Board push-button conditioner: N_BTN independent debounced
// channels with press/release pulses and hold-to-repeat.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   btn_raw      : asynchronous raw button pins
//   btn_level    : debounced pressed levels (1 = pressed)
//   btn_press    : 1-cycle pulses on accepted press
//   btn_release  : 1-cycle pulses on accepted release
//   btn_repeat   : 1-cycle auto-repeat pulses while held
//   btn_event    : btn_press | btn_repeat, registered
module btn_debounce_repeat
   import uart_board_pkg::*;
#(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic [N_BTN-1:0] btn_event
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_repeat  (btn_repeat[i]),
         .btn_event   (btn_event[i])
      );
   end

endmodule
